// File: rtl/seg7_capture.sv
// seg7_capture: debounces an active-low 7-segment pattern ({g,f,e,d,c,b,a}),
// reports each stable pattern once (digit via valid/ready, blank or error as
// one-cycle pulses) and keeps a saturating count of undecodable captures.
module seg7_capture #(
    parameter int DATA_WIDTH    = 3,
    parameter int RESULT_WIDTH  = 7,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [RESULT_WIDTH-1:0] seg_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid,
    input  logic                    ready,
    output logic                    blank,
    output logic                    err,
    output logic [7:0]              err_cnt
);

    typedef enum logic [1:0] {
        TRACK,
        PRESENT,
        WAIT_CHANGE
    } state_t;

    localparam logic [RESULT_WIDTH-1:0] PAT_BLANK = '1;
    // Counter ceiling, and the value it must already hold for the current
    // edge to be the one where it reaches the ceiling.
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] CNT_CAP = 4'(STABLE_CYCLES - 2);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [RESULT_WIDTH-1:0] seg_q, seg_d;
    logic [RESULT_WIDTH-1:0] cap_pat_q, cap_pat_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    blank_q, blank_d;
    logic                    err_q, err_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    // Returns {is_digit, value[2:0]}; anything not a digit decodes to 0.
    function automatic logic [3:0] decode_seg(input logic [RESULT_WIDTH-1:0] pat);
        case (pat)
            RESULT_WIDTH'(7'b1000000): decode_seg = 4'b1_000;
            RESULT_WIDTH'(7'b1111001): decode_seg = 4'b1_001;
            RESULT_WIDTH'(7'b0100100): decode_seg = 4'b1_010;
            RESULT_WIDTH'(7'b0110000): decode_seg = 4'b1_011;
            RESULT_WIDTH'(7'b0011001): decode_seg = 4'b1_100;
            RESULT_WIDTH'(7'b0010010): decode_seg = 4'b1_101;
            RESULT_WIDTH'(7'b0000010): decode_seg = 4'b1_110;
            RESULT_WIDTH'(7'b1111000): decode_seg = 4'b1_111;
            default:                   decode_seg = 4'b0_000;
        endcase
    endfunction

    // Next-state logic: stability tracking, capture classification, handshake.
    always_comb begin
        logic       seg_match;
        logic [3:0] code;

        seg_match  = (seg_in == seg_q);
        code       = decode_seg(seg_in);

        state_d    = state_q;
        seg_d      = seg_in;
        cap_pat_d  = cap_pat_q;
        data_d     = data_q;
        blank_d    = 1'b0;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;

        if (!seg_match) begin
            cnt_d = 4'd0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end

        case (state_q)
            TRACK: begin
                // This edge is the one where the counter reaches its ceiling.
                if (seg_match && (cnt_q >= CNT_CAP)) begin
                    cap_pat_d = seg_in;
                    if (code[3]) begin
                        data_d  = DATA_WIDTH'(code[2:0]);
                        state_d = PRESENT;
                    end else if (seg_in == PAT_BLANK) begin
                        blank_d = 1'b1;
                        state_d = WAIT_CHANGE;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        state_d = WAIT_CHANGE;
                    end
                end
            end
            PRESENT: begin
                if (ready) begin
                    state_d = WAIT_CHANGE;
                end
            end
            WAIT_CHANGE: begin
                // A held pattern is reported once; any change restarts the hold.
                if (seg_in != cap_pat_q) begin
                    cnt_d   = 4'd0;
                    state_d = TRACK;
                end
            end
            default: begin
                state_d = TRACK;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TRACK;
            cnt_q     <= 4'd0;
            seg_q     <= PAT_BLANK;
            cap_pat_q <= PAT_BLANK;
            data_q    <= '0;
            blank_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seg_q     <= seg_d;
            cap_pat_q <= cap_pat_d;
            data_q    <= data_d;
            blank_q   <= blank_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign valid    = (state_q == PRESENT);
    assign data_out = data_q;
    assign blank    = blank_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

endmodule
